axis_pkt_fifo: RTL

Synchronous packet-aware FIFO placed directly downstream of the 2:1 stream mux. It absorbs the muxed 8-bit valid/ready/last stream and decouples the mux from back-pressure at the consumer. In packet mode it holds each packet until its last beat is stored, so downstream logic never sees a packet stall mid-stream because an upstream source went idle.

---
 rtl/axis_pkg.sv | 15 +
 rtl/fifo_ram.sv | 23 ++
 rtl/axis_pkt_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-stream packet path.
package axis_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } axis_beat_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Packet-aware stream FIFO: cut-through or store-and-forward with a deadlock
// escape that drains packets longer than the FIFO once it fills.
module axis_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter bit PKT_MODE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  import axis_pkg::*;

  localparam int AW = ptr_w(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_count_q, pkt_count_d;
  logic          release_q, release_d;

  logic [DATA_W:0] rd_entry;
  logic            full, not_empty, push, pop, pkt_in, pkt_out;

  fifo_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({s_last, s_data}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign full      = (level_q == LW'(DEPTH));
  assign not_empty = (level_q != '0);

  // Handshake: a beat moves on a rising edge only when valid && ready;
  // s_ready and m_valid depend on state only, never on the partner's signal.
  assign s_ready = !full;
  assign m_valid = not_empty &&
                   (!PKT_MODE || (pkt_count_q != '0) || full || release_q);
  assign m_data  = rd_entry[DATA_W-1:0];
  assign m_last  = rd_entry[DATA_W];
  assign level     = level_q;
  assign pkt_count = pkt_count_q;

  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign pkt_in  = push && s_last;
  // A released partial packet can finish with no complete packet counted.
  assign pkt_out = pop && m_last && (pkt_count_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    release_d   = release_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    if (pkt_in && !pkt_out)      pkt_count_d = pkt_count_q + 1'b1;
    else if (pkt_out && !pkt_in) pkt_count_d = pkt_count_q - 1'b1;

    // Escape stays open from the full-with-no-packet point until the
    // oversized packet's last beat leaves.
    if (PKT_MODE) begin
      if (pop && m_last)                           release_d = 1'b0;
      else if (full && (pkt_count_q == '0))        release_d = 1'b1;
    end else begin
      release_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      release_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      release_q   <= release_d;
    end
  end

endmodule
